regfile_write_scheduler: RTL and testbench
==========================================

# regfile_write_scheduler

Arbitrates the single write port of the 16 x 16-bit register file among three writeback requesters: ALU result, memory load and immediate move. Uses round-robin arbitration and a registered write stage. Keeps a per-register pending scoreboard so issue logic can stall on read-after-write hazards. Sits between the execute/memory stages and the register file's `c` / `data` / `load` inputs.

## Interface
- `NREQ`, 3: number of write requesters; index 0 = ALU, 1 = memory, 2 = immediate.
- `AW`, 4: register address width; 16 registers.
- `DW`, 16: data width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `hold`  in  1  when 1, no grants are issued.
- `req_valid`  in  NREQ  per-requester write request.
- `req_addr`  in  NREQ*AW  destination register per requester; requester i in bits [i*AW +: AW].
- `req_data`  in  NREQ*DW  write data per requester; requester i in bits [i*DW +: DW].
- `req_ready`  out  NREQ  one-hot grant; combinational.
- `rsv_valid`  in  1  issue stage reserves a destination register.
- `rsv_addr`  in  AW  register being reserved.
- `wr_c`  out  AW  register-file write address; registered.
- `wr_data`  out  DW  register-file write data; registered.
- `wr_load`  out  1  register-file load enable; registered, one-cycle pulse.
- `pend`  out  16  scoreboard; bit r = 1 while register r has an outstanding write.

## Operation
- Handshake: a transfer on requester i occurs in a cycle where `req_valid[i] & req_ready[i]`.
  - At most one `req_ready` bit is high per cycle.
  - `req_ready` is 0 for every requester when `hold` = 1 or no valid request exists.
  - Requesters must hold `req_addr` and `req_data` stable while `req_valid` = 1 and not yet granted.
- Arbitration: round-robin.
  - State `last` (2 bits, values 0..NREQ-1) records the last granted index.
  - Search order is last+1, last+2, ..., last, all modulo NREQ; the first valid requester wins.
  - `last` updates only on a transfer.
  - Reset value of `last` is NREQ-1, so requester 0 has first priority after reset.
- Write stage: on a transfer, the next edge loads `wr_c` = granted addr, `wr_data` = granted data and `wr_load` = 1.
  - With no transfer, the next edge sets `wr_load` = 0; `wr_c` and `wr_data` hold their values.
  - Back-to-back transfers give consecutive `wr_load` pulses; throughput is one write per cycle.
- Scoreboard, evaluated at every edge:
  - If `wr_load` = 1, clear `pend[wr_c]`.
  - Then, if `rsv_valid` = 1, set `pend[rsv_addr]`.
  - Set wins on same-address conflict: the new reservation supersedes the completing write.
- A write to a register whose `pend` bit is 0 is legal; the clear is a no-op.
- Reserving an already-pending register is legal; the bit stays 1.
- No special case for register 0; all 16 are ordinary.

## Timing
- Reset (`clr` = 0, asynchronous): `wr_load` = 0, `wr_c` = 0, `wr_data` = 0, `pend` = 16'h0000, `last` = NREQ-1.
  - `req_ready` = 0 while in reset.
- Reset mid-operation: an in-flight `wr_load` pulse is dropped and all reservations are lost. Upstream flushes alongside.
- Latency:
  - Grant to `wr_load` high: 1 cycle.
  - The register file captures on the edge after `wr_load` rises.
  - `pend` bit falls on that same edge, so a reader seeing `pend[r]` = 0 reads the new value.
- `hold` is sampled combinationally and blocks grants in the same cycle.
  - `hold` does not affect an already-registered `wr_load`.
- `pend` is registered, with no combinational path from `rsv_valid`.

## Structure
- Shared package `mips_pkg`: `REG_AW` = 4, `REG_DW` = 16, `NUM_REGS` = 16, and requester index constants `WB_ALU` = 0, `WB_MEM` = 1, `WB_IMM` = 2.
- One sub-module: `rr_arbiter`, parameterised by NREQ.
  - Inputs: `req`, `enable`, `advance`.
  - Output: one-hot `grant`.
  - Holds the `last` pointer.
- The write stage and scoreboard are flat in the top module.

## Test plan
- Reset then single request: ALU valid, addr 4'h3, data 16'hBEEF.
  - `req_ready` = 3'b001 in the same cycle.
  - Next cycle `wr_load` = 1, `wr_c` = 3, `wr_data` = BEEF.
  - Following cycle `wr_load` = 0.
- All three requesters valid continuously, addrs 1, 2, 3:
  - Grants follow 0, 1, 2, 0, 1, 2.
  - `wr_load` stays high every cycle after the first.
- `hold` = 1 with all requesters valid for 3 cycles: `req_ready` = 0 and `wr_load` = 0 throughout. Release `hold`: the grant goes to the next index after `last`.
- Scoreboard RAW: reserve r5, then memory writes r5 two cycles later.
  - `pend[5]` = 1 from the edge after the reserve.
  - `pend[5]` clears on the edge after `wr_load` = 1 with `wr_c` = 5.
- Simultaneous clear and set on r7 (`wr_load` with `wr_c` = 7, plus `rsv_valid` with `rsv_addr` = 7): `pend[7]` stays 1.
  - Same cycle with `rsv_addr` = 8 instead: `pend[7]` = 0 and `pend[8]` = 1.
- Assert `clr` low while `wr_load` = 1 and `pend` = 16'h00F0: all outputs go to 0 immediately. After release, a grant goes to requester 0 first.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mips_pkg : shared register-file geometry and writeback requester ids     |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package mips_pkg;

   localparam int REG_AW   = 4;
   localparam int REG_DW   = 16;
   localparam int NUM_REGS = 16;

   localparam int WB_ALU = 0;
   localparam int WB_MEM = 1;
   localparam int WB_IMM = 2;

   // Modulo wrap used by the round-robin search.
   function automatic int wrap_idx(input int v, input int n);
      return v % n;
   endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot arbiter holding the last-grant pointer  |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module rr_arbiter
   import mips_pkg::*;
#(
   parameter int NREQ = 3
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [NREQ-1:0] req,
   input  logic            enable,
   input  logic            advance,
   output logic [NREQ-1:0] grant
);

   localparam int            LW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

   logic [LW-1:0]   r_last;
   logic [LW-1:0]   w_cand;
   logic [LW-1:0]   w_win_idx;
   logic            w_found;
   logic [NREQ-1:0] w_grant;

   // Search starts one past the last winner and wraps, so the last winner
   // is considered only when nobody else is requesting.
   always_comb begin
      w_grant   = '0;
      w_found   = 1'b0;
      w_win_idx = r_last;
      w_cand    = r_last;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = LW'(wrap_idx(int'(r_last) + k, NREQ));
         if (!w_found && req[w_cand]) begin
            w_found          = 1'b1;
            w_win_idx        = w_cand;
            w_grant[w_cand]  = 1'b1;
         end
      end
      if (!enable) begin
         w_grant = '0;
      end
   end

   assign grant = w_grant;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_last <= LAST_RST;
      end else if (advance && w_found) begin
         r_last <= w_win_idx;
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | regfile_write_scheduler : arbitrates the register-file write port and    |
// | tracks outstanding writes in a per-register pending scoreboard. Rev 1.0  |
// +-------------------------------------------------------------------------+
module regfile_write_scheduler
   import mips_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = REG_AW,
   parameter int DW   = REG_DW
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 hold,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 rsv_valid,
   input  logic [AW-1:0]        rsv_addr,
   output logic [AW-1:0]        wr_c,
   output logic [DW-1:0]        wr_data,
   output logic                 wr_load,
   output logic [(1<<AW)-1:0]   pend
);

   logic [NREQ-1:0]    w_grant;
   logic               w_arb_en;
   logic               w_xfer;
   logic [AW-1:0]      w_sel_addr;
   logic [DW-1:0]      w_sel_data;
   logic [(1<<AW)-1:0] w_pend_nxt;

   logic               r_wr_load;
   logic [AW-1:0]      r_wr_c;
   logic [DW-1:0]      r_wr_data;
   logic [(1<<AW)-1:0] r_pend;

   // Gating with clr keeps grants off for the whole reset interval.
   assign w_arb_en = ~hold & clr;

   rr_arbiter #(
      .NREQ    (NREQ)
   ) u_arb (
      .clk     (clk),
      .clr     (clr),
      .req     (req_valid),
      .enable  (w_arb_en),
      .advance (w_xfer),
      .grant   (w_grant)
   );

   assign req_ready = w_grant;
   assign w_xfer    = |(req_valid & w_grant);

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_sel_addr = req_addr[i*AW +: AW];
            w_sel_data = req_data[i*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_wr_load <= 1'b0;
         r_wr_c    <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_load <= w_xfer;
         if (w_xfer) begin
            r_wr_c    <= w_sel_addr;
            r_wr_data <= w_sel_data;
         end
      end
   end

   // Set is applied after clear so a fresh reservation survives a
   // completing write to the same register.
   always_comb begin
      w_pend_nxt = r_pend;
      if (r_wr_load) begin
         w_pend_nxt[r_wr_c] = 1'b0;
      end
      if (rsv_valid) begin
         w_pend_nxt[rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end

   assign wr_load = r_wr_load;
   assign wr_c    = r_wr_c;
   assign wr_data = r_wr_data;
   assign pend    = r_pend;

endmodule : regfile_write_scheduler
`default_nettype wire

// File: tb/tb_regfile_write_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_regfile_write_scheduler : directed + randomized bench with a          |
// | behavioural model of grants, write stage and scoreboard. Rev 1.0         |
// +-------------------------------------------------------------------------+
module tb_regfile_write_scheduler;
   import mips_pkg::*;

   localparam int NREQ = 3;
   localparam int AW   = 4;
   localparam int DW   = 16;

   logic              clk = 1'b0;
   logic              clr;
   logic              hold;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              rsv_valid;
   logic [AW-1:0]     rsv_addr;
   logic [AW-1:0]     wr_c;
   logic [DW-1:0]     wr_data;
   logic              wr_load;
   logic [15:0]       pend;

   always #5 clk = ~clk;

   regfile_write_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .clr       (clr),
      .hold      (hold),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .wr_c      (wr_c),
      .wr_data   (wr_data),
      .wr_load   (wr_load),
      .pend      (pend)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_last;
   bit m_load;
   int m_c;
   int m_data;
   bit m_pend[16];
   int m_grant;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pack_pend();
      logic [15:0] v;
      for (int r = 0; r < 16; r++) v[r] = m_pend[r];
      return v;
   endfunction

   function automatic int model_grant();
      if (hold) return -1;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (m_last + k) % NREQ;
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_last = NREQ - 1;
      m_load = 0;
      m_c    = 0;
      m_data = 0;
      m_grant = -1;
      for (int r = 0; r < 16; r++) m_pend[r] = 0;
   endtask

   task automatic drive(input logic h, input logic [2:0] v, input logic [11:0] a,
                        input logic [47:0] d, input logic rv, input logic [3:0] ra);
      @(negedge clk);
      hold      = h;
      req_valid = v;
      req_addr  = a;
      req_data  = d;
      rsv_valid = rv;
      rsv_addr  = ra;
      #1;
   endtask

   // Checks combinational grant, advances one edge, checks registered outputs.
   task automatic tick(input string tag);
      int g;
      logic [2:0] exp_ready;
      g = model_grant();
      exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
      chk({tag, ".ready"}, 48'(req_ready), 48'(exp_ready));
      @(posedge clk);
      if (m_load) m_pend[m_c] = 0;
      if (rsv_valid) m_pend[rsv_addr] = 1;
      m_load = (g >= 0);
      if (g >= 0) begin
         m_c    = int'(req_addr[g*AW +: AW]);
         m_data = int'(req_data[g*DW +: DW]);
         m_last = g;
      end
      m_grant = g;
      #1;
      chk({tag, ".wr_load"}, 48'(wr_load), 48'(m_load));
      chk({tag, ".wr_c"},    48'(wr_c),    48'(m_c));
      chk({tag, ".wr_data"}, 48'(wr_data), 48'(m_data));
      chk({tag, ".pend"},    48'(pend),    48'(pack_pend()));
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr = 1'b0;
      hold = 0; req_valid = 0; req_addr = 0; req_data = 0; rsv_valid = 0; rsv_addr = 0;
      model_reset();
      #1;
      chk("rst.ready",   48'(req_ready), 48'(0));
      chk("rst.wr_load", 48'(wr_load),   48'(0));
      chk("rst.pend",    48'(pend),      48'(0));
      @(negedge clk);
      clr = 1'b1;
   endtask

   logic [2:0]  r_v;
   logic [11:0] r_a;
   logic [47:0] r_d;

   initial begin
      int exp_seq[6];
      exp_seq = '{1, 2, 4, 1, 2, 4};
      clr = 1'b0;
      hold = 0; req_valid = 0; req_addr = 0; req_data = 0; rsv_valid = 0; rsv_addr = 0;
      model_reset();
      #12;
      chk("init.wr_c",    48'(wr_c),    48'(0));
      chk("init.wr_data", 48'(wr_data), 48'(0));
      do_reset();

      // Single ALU request
      drive(0, 3'b001, 12'h003, 48'h0000_0000_BEEF, 0, 0);
      chk("t1.ready_const", 48'(req_ready), 48'(3'b001));
      tick("t1a");
      chk("t1.load_const", 48'(wr_load), 48'(1));
      chk("t1.c_const",    48'(wr_c),    48'(3));
      chk("t1.data_const", 48'(wr_data), 48'(16'hBEEF));
      drive(0, 3'b000, 12'h000, 48'h0, 0, 0);
      tick("t1b");
      chk("t1.load_off", 48'(wr_load), 48'(0));

      // All three valid: rotating grants
      do_reset();
      drive(0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111}, 0, 0);
      for (int j = 0; j < 6; j++) begin
         if (j > 0) begin
            @(negedge clk);
            #1;
         end
         chk($sformatf("rr.grant%0d", j), 48'(req_ready), 48'(exp_seq[j]));
         tick($sformatf("rr%0d", j));
         chk($sformatf("rr.load%0d", j), 48'(wr_load), 48'(1));
      end

      // Hold blocks grants
      for (int j = 0; j < 3; j++) begin
         drive(1, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111}, 0, 0);
         chk($sformatf("hold.ready%0d", j), 48'(req_ready), 48'(0));
         tick($sformatf("hold%0d", j));
         chk($sformatf("hold.load%0d", j), 48'(wr_load), 48'(0));
      end
      drive(0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111}, 0, 0);
      chk("hold.release", 48'(req_ready), 48'(3'b001));
      tick("rel");

      // Scoreboard RAW on r5
      drive(0, 3'b000, 12'h0, 48'h0, 1, 4'd5);
      tick("raw0");
      chk("raw.set", 48'(pend[5]), 48'(1));
      drive(0, 3'b000, 12'h0, 48'h0, 0, 0);
      tick("raw1");
      drive(0, 3'b010, 12'h050, 48'h0000_5555_0000, 0, 0);
      tick("raw2");
      chk("raw.still", 48'(pend[5]), 48'(1));
      drive(0, 3'b000, 12'h0, 48'h0, 0, 0);
      tick("raw3");
      chk("raw.clear", 48'(pend[5]), 48'(0));

      // Same-address set/clear conflict, then different address
      drive(0, 3'b000, 12'h0, 48'h0, 1, 4'd7);
      tick("cf0");
      drive(0, 3'b010, 12'h070, 48'h0000_7777_0000, 0, 0);
      tick("cf1");
      drive(0, 3'b000, 12'h0, 48'h0, 1, 4'd7);
      tick("cf2");
      chk("cf.same", 48'(pend[7]), 48'(1));
      drive(0, 3'b010, 12'h070, 48'h0000_7778_0000, 0, 0);
      tick("cf3");
      drive(0, 3'b000, 12'h0, 48'h0, 1, 4'd8);
      tick("cf4");
      chk("cf.diff7", 48'(pend[7]), 48'(0));
      chk("cf.diff8", 48'(pend[8]), 48'(1));

      // Reset mid-operation
      do_reset();
      for (int r = 4; r < 8; r++) begin
         drive(0, 3'b000, 12'h0, 48'h0, 1, 4'(r));
         tick($sformatf("mr%0d", r));
      end
      drive(0, 3'b001, 12'h009, 48'h0000_0000_1234, 0, 0);
      tick("mr8");
      chk("mr.load", 48'(wr_load), 48'(1));
      chk("mr.pend", 48'(pend), 48'(16'h00F0));
      drive(0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111}, 0, 0);
      clr = 1'b0;
      model_reset();
      #1;
      chk("mr.rst_load", 48'(wr_load),   48'(0));
      chk("mr.rst_c",    48'(wr_c),      48'(0));
      chk("mr.rst_data", 48'(wr_data),   48'(0));
      chk("mr.rst_pend", 48'(pend),      48'(0));
      chk("mr.rst_rdy",  48'(req_ready), 48'(0));
      @(negedge clk);
      clr = 1'b1;
      #1;
      chk("mr.first", 48'(req_ready), 48'(3'b001));
      tick("mr9");

      // Randomized traffic; un-granted requests stay stable
      r_v = 0; r_a = 0; r_d = 0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!(r_v[i] && m_grant != i && n > 0) || !r_v[i]) begin
               r_v[i] = ($urandom_range(0, 9) < 6);
               r_a[i*AW +: AW] = 4'($urandom_range(0, 15));
               r_d[i*DW +: DW] = 16'($urandom);
            end
         end
         drive(($urandom_range(0, 9) == 0), r_v, r_a, r_d,
               ($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)));
         tick($sformatf("rnd%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_regfile_write_scheduler
`default_nettype wire
